// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared BT.656 decode types, preamble constants and the XY
//                protection-bit check.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } bt656_state_t;

    localparam logic [7:0] BT656_PRE0 = 8'hFF;
    localparam logic [7:0] BT656_PRE1 = 8'h00;

    // XY = {1, F, V, H, P3, P2, P1, P0}
    function automatic logic bt656_xy_ok(input logic [7:0] xy);
        logic fb;
        logic vb;
        logic hb;
        fb = xy[6];
        vb = xy[5];
        hb = xy[4];
        return xy[3:0] == {vb ^ hb, fb ^ hb, fb ^ vb, fb ^ vb ^ hb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bt656_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bt656_decoder_if
//  Description : Byte-stream input and decoded pixel/timing outputs of the
//                BT.656 decoder. master = stream source, slave = decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bt656_decoder_if #(
    parameter int W_BITS = 12
);
    logic [7:0]        bt656_data;
    logic              pixel_de;
    logic [15:0]       pixel_yc;
    logic              vs;
    logic              hs;
    logic              f;
    logic [W_BITS-1:0] meas_width;
    logic [W_BITS-1:0] meas_height;
    logic              sync_lock;
    logic [7:0]        prot_err_cnt;

    modport master (
        output bt656_data,
        input  pixel_de, pixel_yc, vs, hs, f,
        input  meas_width, meas_height, sync_lock, prot_err_cnt
    );

    modport slave (
        input  bt656_data,
        output pixel_de, pixel_yc, vs, hs, f,
        output meas_width, meas_height, sync_lock, prot_err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bt656_xy_detect.sv
`default_nettype none
// ============================================================================
//  Module      : bt656_xy_detect
//  Description : Four-byte input shift register, FF 00 00 preamble match and
//                XY (F/V/H + protection) decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module bt656_xy_detect
    import video_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [7:0] bt656_data,
    output logic [7:0] byte_q,
    output logic       code_vld,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       prot_ok
);

    logic [7:0] r_d0;
    logic [7:0] r_d1;
    logic [7:0] r_d2;
    logic [7:0] r_d3;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_d0 <= 8'h00;
            r_d1 <= 8'h00;
            r_d2 <= 8'h00;
            r_d3 <= 8'h00;
        end else begin
            r_d0 <= bt656_data;
            r_d1 <= r_d0;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
        end
    end

    assign byte_q   = r_d0;
    assign code_vld = (r_d3 == BT656_PRE0) && (r_d2 == BT656_PRE1) &&
                      (r_d1 == BT656_PRE1) && r_d0[7];
    assign f        = r_d0[6];
    assign v        = r_d0[5];
    assign h        = r_d0[4];
    assign prot_ok  = bt656_xy_ok(r_d0);

endmodule
`default_nettype wire

// File: rtl/bt656_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bt656_decoder
//  Description : BT.656 byte stream to 16-bit YC pixels with V/H/F flags,
//                active width/height measurement and sync lock.
//                Define BT656_PROT_CHECK_EN to reject XY codes with bad
//                protection bits and count them in prot_err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module bt656_decoder
    import video_pkg::*;
#(
    parameter int W_BITS = 12
)(
    input  logic           pixel_clk,
    input  logic           rst,
    bt656_decoder_if.slave bus
);

    localparam logic [W_BITS-1:0] c_cnt_max = {W_BITS{1'b1}};
    localparam logic [W_BITS-1:0] c_cnt_one = {{(W_BITS-1){1'b0}}, 1'b1};
`ifdef BT656_PROT_CHECK_EN
    localparam logic c_trust_xy = 1'b0;
`else
    localparam logic c_trust_xy = 1'b1;
`endif

    logic [7:0]        w_byte;
    logic              w_code_vld;
    logic              w_f;
    logic              w_v;
    logic              w_h;
    logic              w_prot_ok;
    logic              w_code_seen;
    logic              w_accept;
    logic              w_reject;
    logic [W_BITS-1:0] w_width_inc;
    logic [W_BITS-1:0] w_line_inc;
    logic [W_BITS-1:0] w_line_next;

    bt656_state_t      r_state;
    logic [1:0]        r_phase;
    logic [7:0]        r_cb;
    logic [7:0]        r_cr;
    logic              r_de;
    logic [15:0]       r_yc;
    logic              r_vs;
    logic              r_hs;
    logic              r_f;
    logic [W_BITS-1:0] r_width_cnt;
    logic [W_BITS-1:0] r_line_cnt;
    logic [W_BITS-1:0] r_meas_w;
    logic [W_BITS-1:0] r_meas_h;
    logic [2:0]        r_lock_cnt;
    logic              r_lock;

    bt656_xy_detect u_xy_detect (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .bt656_data (bus.bt656_data),
        .byte_q     (w_byte),
        .code_vld   (w_code_vld),
        .f          (w_f),
        .v          (w_v),
        .h          (w_h),
        .prot_ok    (w_prot_ok)
    );

    // In ACTIVE the FF preamble byte leaves the state before any code completes.
    assign w_code_seen = w_code_vld && (r_state != ACTIVE);
    assign w_accept    = w_code_seen && (w_prot_ok || c_trust_xy);
    assign w_reject    = w_code_seen && !w_accept;

    assign w_width_inc = (r_width_cnt == c_cnt_max) ? r_width_cnt : r_width_cnt + c_cnt_one;
    assign w_line_inc  = (r_line_cnt == c_cnt_max) ? r_line_cnt : r_line_cnt + c_cnt_one;
    assign w_line_next = (w_h && (r_width_cnt != '0)) ? w_line_inc : r_line_cnt;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_phase     <= 2'd0;
            r_cb        <= 8'h00;
            r_cr        <= 8'h00;
            r_de        <= 1'b0;
            r_yc        <= 16'h0000;
            r_vs        <= 1'b0;
            r_hs        <= 1'b0;
            r_f         <= 1'b0;
            r_width_cnt <= '0;
            r_line_cnt  <= '0;
            r_meas_w    <= '0;
            r_meas_h    <= '0;
            r_lock_cnt  <= 3'd0;
            r_lock      <= 1'b0;
        end else begin
            r_de <= 1'b0;
            if (r_state == ACTIVE) begin
                if (w_byte == BT656_PRE0) begin
                    r_state <= BLANK;
                end else begin
                    r_phase <= r_phase + 2'd1;
                    case (r_phase)
                        2'd0: r_cb <= w_byte;
                        2'd1: begin
                            r_de        <= 1'b1;
                            r_yc        <= {w_byte, r_cb};
                            r_width_cnt <= w_width_inc;
                        end
                        2'd2: r_cr <= w_byte;
                        2'd3: begin
                            r_de        <= 1'b1;
                            r_yc        <= {w_byte, r_cr};
                            r_width_cnt <= w_width_inc;
                        end
                    endcase
                end
            end else if (w_accept) begin
                r_f  <= w_f;
                r_vs <= w_v;
                r_hs <= w_h;
                if (r_lock_cnt != 3'd4) begin
                    r_lock_cnt <= r_lock_cnt + 3'd1;
                end
                r_lock <= (r_lock_cnt >= 3'd3);
                if (w_h) begin
                    r_state     <= BLANK;
                    r_width_cnt <= '0;
                    if (r_width_cnt != '0) begin
                        r_meas_w <= r_width_cnt;
                    end
                end else begin
                    r_state <= w_v ? BLANK : ACTIVE;
                    r_phase <= 2'd0;
                end
                // A line closed by this same EAV is counted into the field it ends.
                if (w_v && !r_vs) begin
                    r_meas_h   <= w_line_next;
                    r_line_cnt <= '0;
                end else begin
                    r_line_cnt <= w_line_next;
                end
            end else if (w_reject) begin
                r_lock_cnt <= 3'd0;
                r_lock     <= 1'b0;
            end
        end
    end

`ifdef BT656_PROT_CHECK_EN
    logic [7:0] r_prot_err;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_prot_err <= 8'h00;
        end else if (w_reject && (r_prot_err != 8'hFF)) begin
            r_prot_err <= r_prot_err + 8'h01;
        end
    end

    assign bus.prot_err_cnt = r_prot_err;
`else
    assign bus.prot_err_cnt = 8'h00;
`endif

    assign bus.pixel_de    = r_de;
    assign bus.pixel_yc    = r_yc;
    assign bus.vs          = r_vs;
    assign bus.hs          = r_hs;
    assign bus.f           = r_f;
    assign bus.meas_width  = r_meas_w;
    assign bus.meas_height = r_meas_h;
    assign bus.sync_lock   = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_bt656_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bt656_decoder
//  Description : Self-checking bench for bt656_decoder; expected pixels are
//                queued as Y bytes are driven and matched on pixel_de.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bt656_decoder;
    import video_pkg::*;

    typedef struct {
        int          cyc;
        logic [15:0] yc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_de = 1'b0;
    exp_t q[$];

    bt656_decoder_if #(.W_BITS(12)) bus ();

    bt656_decoder #(.W_BITS(12)) dut (
        .pixel_clk (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pixel_de === 1'b1) begin
            checks++;
            if (prev_de === 1'b1) begin
                failures++;
                $display("FAIL de_consecutive at cycle %0d", cyc);
            end
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_de cycle=%0d yc=%h", cyc, bus.pixel_yc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.pixel_yc !== e.yc || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL pixel yc=%h at cycle %0d, expected yc=%h at cycle %0d",
                             bus.pixel_yc, cyc, e.yc, e.cyc);
                end
            end
        end
        prev_de = bus.pixel_de;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.bt656_data = b;
    endtask

    task automatic put_y(input logic [7:0] y, input logic [7:0] c);
        exp_t e;
        put(y);
        e.cyc = cyc + 2;
        e.yc  = {y, c};
        q.push_back(e);
    endtask

    task automatic send_quad(input logic [7:0] cb, input logic [7:0] y0,
                             input logic [7:0] cr, input logic [7:0] y1);
        put(cb);
        put_y(y0, cb);
        put(cr);
        put_y(y1, cr);
    endtask

    function automatic logic [7:0] rnd();
        return 8'($urandom_range(0, 254));
    endfunction

    task automatic send_random_pixels(input int n);
        for (int i = 0; i < n / 2; i++) send_quad(rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic send_code(input logic [7:0] xy);
        put(BT656_PRE0);
        put(BT656_PRE1);
        put(BT656_PRE1);
        put(xy);
    endtask

    task automatic idle(input int n);
        repeat (n) put(8'h10);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 && q.size() != 0; i++) put(8'h10);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_pixels remaining=%0d required=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [62:0] obs;
        obs = {bus.pixel_de, bus.pixel_yc, bus.vs, bus.hs, bus.f, bus.meas_width,
               bus.meas_height, bus.sync_lock, bus.prot_err_cnt};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL %s outputs=%h required=0", name, obs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.bt656_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_single_line();
        send_code(8'h80);
        send_quad(8'h10, 8'h20, 8'h30, 8'h40);
        send_quad(8'h50, 8'h60, 8'h70, 8'h80);
        send_code(8'h9D);
        idle(1);
        checks++;
        if (bus.meas_width !== 12'd0) begin
            failures++;
            $display("FAIL line_width_early actual=%0d required=0", bus.meas_width);
        end
        idle(1);
        checks++;
        if (bus.meas_width !== 12'd4) begin
            failures++;
            $display("FAIL line_width actual=%0d required=4", bus.meas_width);
        end
        checks++;
        if ({bus.vs, bus.hs, bus.f} !== 3'b010) begin
            failures++;
            $display("FAIL line_flags vs/hs/f=%b required=010", {bus.vs, bus.hs, bus.f});
        end
        drain("line");
    endtask

    task automatic test_vblank_sav();
        send_code(8'hAB);
        repeat (8) put(rnd());
        checks++;
        if ({bus.vs, bus.hs} !== 2'b10) begin
            failures++;
            $display("FAIL vblank_flags vs/hs=%b required=10", {bus.vs, bus.hs});
        end
        checks++;
        if (bus.sync_lock !== 1'b0) begin
            failures++;
            $display("FAIL lock_after_3_codes actual=%b required=0", bus.sync_lock);
        end
        idle(2);
        drain("vblank");
    endtask

    task automatic test_frame();
        for (int l = 0; l < 3; l++) begin
            send_code(8'h80);
            send_random_pixels(720);
            send_code(8'h9D);
            idle(4);
        end
        send_code(8'hB6);
        idle(2);
        checks++;
        if (bus.meas_height !== 12'd3) begin
            failures++;
            $display("FAIL frame_height actual=%0d required=3", bus.meas_height);
        end
        checks++;
        if (bus.meas_width !== 12'd720) begin
            failures++;
            $display("FAIL frame_width actual=%0d required=720", bus.meas_width);
        end
        checks++;
        if ({bus.vs, bus.hs, bus.sync_lock} !== 3'b111) begin
            failures++;
            $display("FAIL frame_flags vs/hs/lock=%b required=111",
                     {bus.vs, bus.hs, bus.sync_lock});
        end
        drain("frame");
    endtask

    task automatic test_prot_error();
        send_code(8'h81);
`ifdef BT656_PROT_CHECK_EN
        repeat (4) put(rnd());
        checks++;
        if ({bus.prot_err_cnt, bus.sync_lock, bus.vs, bus.hs} !== {8'd1, 3'b011}) begin
            failures++;
            $display("FAIL prot_reject err/lock/vs/hs=%h/%b/%b/%b required=01/0/1/1",
                     bus.prot_err_cnt, bus.sync_lock, bus.vs, bus.hs);
        end
`else
        send_quad(rnd(), rnd(), rnd(), rnd());
        checks++;
        if ({bus.prot_err_cnt, bus.sync_lock, bus.vs, bus.hs} !== {8'd0, 3'b100}) begin
            failures++;
            $display("FAIL prot_trust err/lock/vs/hs=%h/%b/%b/%b required=00/1/0/0",
                     bus.prot_err_cnt, bus.sync_lock, bus.vs, bus.hs);
        end
`endif
        send_code(8'h9D);
        idle(3);
        drain("prot");
    endtask

    task automatic test_field_flag();
        send_code(8'hC7);
        put(8'h11);
        checks++;
        if (bus.f !== 1'b0) begin
            failures++;
            $display("FAIL f_early actual=%b required=0", bus.f);
        end
        put_y(8'h22, 8'h11);
        checks++;
        if (bus.f !== 1'b1) begin
            failures++;
            $display("FAIL f_set actual=%b required=1", bus.f);
        end
        put(8'h33);
        put_y(8'h44, 8'h33);
        send_code(8'h9D);
        idle(3);
        drain("field");
    endtask

    task automatic test_reset_midline();
        send_code(8'h80);
        send_quad(rnd(), rnd(), rnd(), rnd());
        send_quad(rnd(), rnd(), rnd(), rnd());
        put(rnd());
        put(rnd());
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midline_reset");
        rst = 1'b0;
        repeat (16) put(rnd());
        send_code(8'h80);
        send_quad(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        send_code(8'h9D);
        idle(3);
        checks++;
        if (bus.meas_width !== 12'd2) begin
            failures++;
            $display("FAIL after_reset_width actual=%0d required=2", bus.meas_width);
        end
        drain("after_reset");
    endtask

    initial begin
        rst = 1'b1;
        bus.bt656_data = 8'h00;
        test_reset();
        test_single_line();
        test_vblank_sav();
        test_frame();
        test_prot_error();
        test_field_flag();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
